// File: rtl/pcu_csr_fwd_unit.sv
// pcu_csr_fwd_unit: machine CSR group with a debug read port, plus the
// operand-forwarding and load-use/redirect hazard logic of the 5-stage RV32I
// pipeline control unit.
module pcu_csr_fwd_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [31:0] mtevc_din,
  input  logic [31:0] mcause_din,
  input  logic [31:0] mepc_din,
  input  logic [31:0] mtval_din,
  input  logic [31:0] mipd_din,
  input  logic [31:0] bs_din,
  output logic [31:0] mtevc_dout,
  output logic [31:0] mcause_dout,
  output logic [31:0] mepc_dout,
  output logic [31:0] mtval_dout,
  output logic [31:0] mipd_dout,
  output logic [31:0] bs_dout,
  input  logic [11:0] csr_debug_addr,
  output logic [31:0] csr_debug_dout,
  input  logic [31:0] id_is,
  input  logic [31:0] ex_is,
  input  logic [31:0] mem_is,
  input  logic [31:0] wb_is,
  input  logic [2:0]  npc_mux_sel,
  output logic [2:0]  b_sr1_mux_sel_fh,
  output logic [2:0]  b_sr2_mux_sel_fh,
  output logic [2:0]  sr1_mux_sel_fh,
  output logic [2:0]  sr2_mux_sel_fh,
  output logic [2:0]  dm_sr2_mux_sel_fh,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_clear,
  output logic        id_ex_clear
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] SEL_RF  = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_WB  = 3'd2;

  logic [31:0] mtevc_q, mcause_q, mepc_q, mtval_q, mipd_q, bs_q;
  logic [31:0] mtevc_d, mcause_d, mepc_d, mtval_d, mipd_d, bs_d;

  // Instruction produces a register write to a non-zero rd.
  function automatic logic writes_rd(input logic [31:0] is);
    logic [6:0] op;
    logic       wr;
    op = is[6:0];
    wr = (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) || (op == OP_JAL) ||
         (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC) ||
         ((op == OP_SYS) && (is[14:12] != 3'd0));
    return wr && (is[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] is);
    logic [6:0] op;
    op = is[6:0];
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JALR) ||
           ((op == OP_SYS) && (is[14:12] != 3'd0));
  endfunction

  function automatic logic uses_rs2(input logic [31:0] is);
    logic [6:0] op;
    op = is[6:0];
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Forwarding source for one register; loads in MEM have no data yet, so
  // they are skipped and the WB stage gets a chance to match instead.
  function automatic logic [2:0] fwd_src(input logic [4:0] rs);
    logic [2:0] sel;
    sel = SEL_RF;
    if (rs != 5'd0) begin
      if (writes_rd(mem_is) && (mem_is[11:7] == rs) && (mem_is[6:0] != OP_LOAD))
        sel = SEL_MEM;
      else if (writes_rd(wb_is) && (wb_is[11:7] == rs))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  // Group CSR write: every register takes its din together, else holds.
  always_comb begin
    mtevc_d  = mtevc_q;
    mcause_d = mcause_q;
    mepc_d   = mepc_q;
    mtval_d  = mtval_q;
    mipd_d   = mipd_q;
    bs_d     = bs_q;
    if (csr_we) begin
      mtevc_d  = mtevc_din;
      mcause_d = mcause_din;
      mepc_d   = mepc_din;
      mtval_d  = mtval_din;
      mipd_d   = mipd_din;
      bs_d     = bs_din;
    end
  end

  // CSR storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtevc_q  <= '0;
      mcause_q <= '0;
      mepc_q   <= '0;
      mtval_q  <= '0;
      mipd_q   <= '0;
      bs_q     <= '0;
    end else begin
      mtevc_q  <= mtevc_d;
      mcause_q <= mcause_d;
      mepc_q   <= mepc_d;
      mtval_q  <= mtval_d;
      mipd_q   <= mipd_d;
      bs_q     <= bs_d;
    end
  end

  assign mtevc_dout  = mtevc_q;
  assign mcause_dout = mcause_q;
  assign mepc_dout   = mepc_q;
  assign mtval_dout  = mtval_q;
  assign mipd_dout   = mipd_q;
  assign bs_dout     = bs_q;

  // Debug read mux; unmapped addresses read as zero.
  always_comb begin
    csr_debug_dout = 32'd0;
    case (csr_debug_addr)
      12'h305: csr_debug_dout = mtevc_q;
      12'h342: csr_debug_dout = mcause_q;
      12'h341: csr_debug_dout = mepc_q;
      12'h343: csr_debug_dout = mtval_q;
      12'h100: csr_debug_dout = mipd_q;
      12'h000: csr_debug_dout = bs_q;
      default: csr_debug_dout = 32'd0;
    endcase
  end

  // Forwarding selects for the instruction currently in EX.
  always_comb begin
    logic [2:0] f1, f2;
    logic [6:0] op;
    f1 = fwd_src(ex_is[19:15]);
    f2 = fwd_src(ex_is[24:20]);
    op = ex_is[6:0];
    b_sr1_mux_sel_fh  = (op == OP_BRANCH) ? f1 : SEL_RF;
    b_sr2_mux_sel_fh  = (op == OP_BRANCH) ? f2 : SEL_RF;
    sr1_mux_sel_fh    = uses_rs1(ex_is)   ? f1 : SEL_RF;
    sr2_mux_sel_fh    = (op == OP_R)      ? f2 : SEL_RF;
    dm_sr2_mux_sel_fh = (op == OP_STORE)  ? f2 : SEL_RF;
  end

  // Hazard control: a taken redirect flushes and wins over a load-use stall.
  always_comb begin
    logic ld_use;
    ld_use = (ex_is[6:0] == OP_LOAD) && (ex_is[11:7] != 5'd0) &&
             ((uses_rs1(id_is) && (id_is[19:15] == ex_is[11:7])) ||
              (uses_rs2(id_is) && (id_is[24:20] == ex_is[11:7])));
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_clear = 1'b0;
    id_ex_clear = 1'b0;
    if (npc_mux_sel != 3'd0) begin
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
    end else if (ld_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

endmodule

// File: tb/tb_pcu_csr_fwd_unit.sv
// Scoreboard bench for pcu_csr_fwd_unit: a driver applies one transaction per
// cycle and queues the reference model's expected outputs; a monitor pops and
// compares them on the falling edge.
module tb_pcu_csr_fwd_unit;

  logic        clk, rst, csr_we;
  logic [31:0] mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din;
  logic [31:0] mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout;
  logic [11:0] csr_debug_addr;
  logic [31:0] csr_debug_dout;
  logic [31:0] id_is, ex_is, mem_is, wb_is;
  logic [2:0]  npc_mux_sel;
  logic [2:0]  b_sr1_mux_sel_fh, b_sr2_mux_sel_fh, sr1_mux_sel_fh, sr2_mux_sel_fh, dm_sr2_mux_sel_fh;
  logic        pc_en, if_id_en, if_id_clear, id_ex_clear;

  pcu_csr_fwd_unit dut (
    .clk(clk), .rst(rst), .csr_we(csr_we),
    .mtevc_din(mtevc_din), .mcause_din(mcause_din), .mepc_din(mepc_din),
    .mtval_din(mtval_din), .mipd_din(mipd_din), .bs_din(bs_din),
    .mtevc_dout(mtevc_dout), .mcause_dout(mcause_dout), .mepc_dout(mepc_dout),
    .mtval_dout(mtval_dout), .mipd_dout(mipd_dout), .bs_dout(bs_dout),
    .csr_debug_addr(csr_debug_addr), .csr_debug_dout(csr_debug_dout),
    .id_is(id_is), .ex_is(ex_is), .mem_is(mem_is), .wb_is(wb_is),
    .npc_mux_sel(npc_mux_sel),
    .b_sr1_mux_sel_fh(b_sr1_mux_sel_fh), .b_sr2_mux_sel_fh(b_sr2_mux_sel_fh),
    .sr1_mux_sel_fh(sr1_mux_sel_fh), .sr2_mux_sel_fh(sr2_mux_sel_fh),
    .dm_sr2_mux_sel_fh(dm_sr2_mux_sel_fh),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][31:0] csr;  // mtevc, mcause, mepc, mtval, mipd, bs
    logic [31:0]      dbg;
    logic [4:0][2:0]  sel;  // b_sr1, b_sr2, sr1, sr2, dm_sr2
    logic [3:0]       hz;   // pc_en, if_id_en, if_id_clear, id_ex_clear
  } exp_t;

  exp_t             sb_q[$];
  logic [5:0][31:0] m_csr;
  int               n_cmp = 0;
  int               n_mis = 0;
  int               n_txn = 0;

  localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, SYS = 7'b1110011;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int f3,
                                     input int rs1, input int rs2);
    return {7'd0, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  // Reference decode, straight from the instruction-class tables.
  function automatic bit m_wr(input logic [31:0] is);
    bit cls;
    cls = (is[6:0] inside {R, IA, LD, JAL, JALR, LUI, AUI}) || (is[6:0] == SYS && is[14:12] != 0);
    return cls && is[11:7] != 0;
  endfunction
  function automatic bit m_r1(input logic [31:0] is);
    return (is[6:0] inside {R, IA, LD, ST, BR, JALR}) || (is[6:0] == SYS && is[14:12] != 0);
  endfunction
  function automatic bit m_r2(input logic [31:0] is);
    return is[6:0] inside {R, ST, BR};
  endfunction

  // Walk the producers youngest first; first usable one names the source.
  function automatic logic [2:0] m_fwd(input logic [4:0] rs, input logic [31:0] mem, input logic [31:0] wb);
    logic [31:0] prod [2];
    prod[0] = mem;
    prod[1] = wb;
    if (rs == 0) return 3'd0;
    for (int k = 0; k < 2; k++) begin
      if (m_wr(prod[k]) && prod[k][11:7] == rs && !(k == 0 && prod[k][6:0] == LD))
        return 3'(k + 1);
    end
    return 3'd0;
  endfunction

  function automatic exp_t model(input logic [11:0] addr);
    exp_t        e;
    logic [11:0] amap [6];
    logic [2:0]  f1, f2;
    bit          lu;
    amap = '{12'h305, 12'h342, 12'h341, 12'h343, 12'h100, 12'h000};
    e.csr = m_csr;
    e.dbg = 32'd0;
    for (int k = 0; k < 6; k++) if (amap[k] == addr) e.dbg = m_csr[5 - k];
    f1 = m_fwd(ex_is[19:15], mem_is, wb_is);
    f2 = m_fwd(ex_is[24:20], mem_is, wb_is);
    e.sel[4] = (ex_is[6:0] == BR) ? f1 : 3'd0;
    e.sel[3] = (ex_is[6:0] == BR) ? f2 : 3'd0;
    e.sel[2] = m_r1(ex_is) ? f1 : 3'd0;
    e.sel[1] = (ex_is[6:0] == R) ? f2 : 3'd0;
    e.sel[0] = (ex_is[6:0] == ST) ? f2 : 3'd0;
    lu = ex_is[6:0] == LD && ex_is[11:7] != 0 &&
         ((m_r1(id_is) && id_is[19:15] == ex_is[11:7]) || (m_r2(id_is) && id_is[24:20] == ex_is[11:7]));
    if (npc_mux_sel != 0) e.hz = 4'b1111;
    else if (lu)          e.hz = 4'b0001;
    else                  e.hz = 4'b1100;
    return e;
  endfunction

  // One transaction: apply inputs just after the rising edge, queue expectation,
  // then advance the CSR model across the coming edge.
  task automatic step(input logic r, input logic we, input logic [5:0][31:0] din,
                      input logic [11:0] addr, input logic [31:0] id, input logic [31:0] ex,
                      input logic [31:0] mem, input logic [31:0] wb, input logic [2:0] npc);
    @(posedge clk);
    #1;
    rst = r; csr_we = we;
    {mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din} = din;
    csr_debug_addr = addr;
    id_is = id; ex_is = ex; mem_is = mem; wb_is = wb; npc_mux_sel = npc;
    if (r) m_csr = '0;
    sb_q.push_back(model(addr));
    n_txn++;
    if (!r && we) m_csr = din;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    string cn [6];
    string sn [5];
    exp_t  e;
    cn = '{"mtevc", "mcause", "mepc", "mtval", "mipd", "bs"};
    sn = '{"b_sr1", "b_sr2", "sr1", "sr2", "dm_sr2"};
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        logic [5:0][31:0] ac;
        logic [4:0][2:0]  as;
        e  = sb_q.pop_front();
        ac = {mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout};
        as = {b_sr1_mux_sel_fh, b_sr2_mux_sel_fh, sr1_mux_sel_fh, sr2_mux_sel_fh, dm_sr2_mux_sel_fh};
        for (int k = 0; k < 6; k++) chk(cn[k], ac[5 - k], e.csr[5 - k]);
        chk("debug", csr_debug_dout, e.dbg);
        for (int k = 0; k < 5; k++) chk(sn[k], 32'(as[4 - k]), 32'(e.sel[4 - k]));
        chk("hazard", 32'({pc_en, if_id_en, if_id_clear, id_ex_clear}), 32'(e.hz));
        $display("txn ex=%h mem=%h wb=%h id=%h npc=%0d dbg=%h hz=%b", ex_is, mem_is, wb_is,
                 id_is, npc_mux_sel, csr_debug_dout, {pc_en, if_id_en, if_id_clear, id_ex_clear});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0][31:0] d0, d1, dr;
    logic [6:0]       ops [11];
    logic [31:0]      ins [4];
    logic [11:0]      adr [7];
    ops = '{R, IA, LD, ST, BR, JAL, JALR, LUI, AUI, SYS, 7'b1111111};
    adr = '{12'h305, 12'h342, 12'h341, 12'h343, 12'h100, 12'h000, 12'h7FF};
    m_csr = '0;
    rst = 1'b1; csr_we = 1'b0; csr_debug_addr = '0;
    {mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din} = '0;
    id_is = '0; ex_is = '0; mem_is = '0; wb_is = '0; npc_mux_sel = '0;
    d0 = '0;
    d1 = '0;
    d1[3] = 32'h1234;  // mepc
    d1[1] = 32'h1;     // mipd
    // CSR write then debug reads.
    step(1, 0, d0, 12'h341, 0, 0, 0, 0, 0);
    step(0, 1, d1, 12'h341, 0, 0, 0, 0, 0);
    step(0, 0, d0, 12'h341, 0, 0, 0, 0, 0);
    step(0, 0, d0, 12'h7FF, 0, 0, 0, 0, 0);
    // MEM forwarding, then MEM priority over WB.
    step(0, 0, d0, 12'h100, 0, mk(R, 6, 0, 5, 5), mk(R, 5, 0, 1, 2), 0, 0);
    step(0, 0, d0, 12'h100, 0, mk(R, 6, 0, 5, 5), mk(R, 5, 0, 1, 2), mk(IA, 5, 0, 3, 0), 0);
    // Load-use stall, then redirect overriding it.
    step(0, 0, d0, 12'h000, mk(R, 8, 0, 7, 0), mk(LD, 7, 2, 1, 0), 0, 0, 0);
    step(0, 0, d0, 12'h000, mk(R, 8, 0, 7, 0), mk(LD, 7, 2, 1, 0), 0, 0, 1);
    // WB forwarding of a load into a branch.
    step(0, 0, d0, 12'h000, 0, mk(BR, 0, 0, 9, 0), 0, mk(LD, 9, 2, 1, 0), 0);
    // Store data forwarding; x0 destination never forwards.
    step(0, 0, d0, 12'h000, 0, mk(ST, 0, 2, 4, 3), mk(R, 3, 0, 1, 2), 0, 0);
    step(0, 0, d0, 12'h000, 0, mk(R, 6, 0, 0, 0), mk(R, 0, 0, 1, 2), 0, 0);
    // Reset during a held write clears immediately and stays clear.
    step(0, 1, {6{32'hA5A5_0001}}, 12'h305, 0, 0, 0, 0, 0);
    step(1, 1, {6{32'hDEAD_BEEF}}, 12'h305, 0, 0, 0, 0, 0);
    step(1, 1, {6{32'hDEAD_BEEF}}, 12'h305, 0, 0, 0, 0, 0);
    step(0, 1, {6{32'h0000_0042}}, 12'h342, 0, 0, 0, 0, 0);
    step(0, 0, d0, 12'h342, 0, 0, 0, 0, 0);
    // Randomized traffic over a small register window to provoke matches.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 4; k++)
        ins[k] = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 7),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      for (int k = 0; k < 6; k++) dr[k] = $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), dr, adr[$urandom_range(0, 6)],
           ins[0], ins[1], ins[2], ins[3],
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pcu_csr_fwd_unit.md
# pcu_csr_fwd_unit

Combined CSR storage and forwarding/hazard unit inside the pipeline control unit (PCU) of the 5-stage RV32I CPU. It holds the six machine CSRs, written as a group under a single write enable, with a combinational debug read port. From the ID/EX/MEM/WB instruction words and the EX next-PC select, it computes the operand-forwarding selects and the stall/flush controls.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock; CSRs update on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all CSRs
- csr_we  in  1  group write enable for all six CSRs
- mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din  in  32 each  next CSR values
- mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout  out  32 each  current CSR values
- csr_debug_addr  in  12  debug CSR address
- csr_debug_dout  out  32  debug read data
- id_is, ex_is, mem_is, wb_is  in  32 each  instruction word in each stage (0 = bubble)
- npc_mux_sel  in  3  EX next-PC select; 0 = PC+4, nonzero = taken branch/jump
- b_sr1_mux_sel_fh, b_sr2_mux_sel_fh  out  3  forwarding selects for the EX branch comparator rs1/rs2
- sr1_mux_sel_fh, sr2_mux_sel_fh  out  3  forwarding selects for the EX ALU rs1/rs2
- dm_sr2_mux_sel_fh  out  3  forwarding select for the EX store data (rs2)
- pc_en, if_id_en  out  1  PC / IF-ID register write enables
- if_id_clear, id_ex_clear  out  1  pipeline register flushes

## Operation
- CSR write: on a rising clk edge with csr_we=1, all six registers load their din; otherwise they hold. Callers pass the current value for any CSR that must not change.
- CSR read: each dout equals its register value, with no bypass of din.
- Debug read: combinational. Address map: 0x305 mtevc, 0x342 mcause, 0x341 mepc, 0x343 mtval, 0x100 mipd, 0x000 bs. Any other address reads 0.
- Decode on opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Writes rd: R 0110011, I-ALU 0010011, load 0000011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, and SYSTEM 1110011 with funct3≠0. Requires rd≠0.
- Uses rs1: R, I-ALU, load, store 0100011, branch 1100011, JALR, SYSTEM CSR. Uses rs2: R, store, branch.
- Select encoding: 0 = register-file value, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data. Codes 3–7 are never driven.
- Forwarding is evaluated for ex_is, per source:
  - Code 1 if mem_is writes a matching rd and is not a load.
  - Else code 2 if wb_is writes a matching rd.
  - Else code 0.
  - MEM has priority over WB.
- Per-select qualification:
  - b_sr1/b_sr2 are nonzero only for branch instructions.
  - sr1 is nonzero for instructions that use rs1.
  - sr2 is nonzero only for R-type.
  - dm_sr2 is nonzero only for stores.
  - Source register x0 always yields code 0.
- Load-use stall: ex_is is a load with rd≠0, and id_is uses rs1 or rs2 equal to that rd. Response: pc_en=0, if_id_en=0, id_ex_clear=1, if_id_clear=0.
- Redirect: npc_mux_sel≠0. Response: pc_en=1, if_id_en=1, if_id_clear=1, id_ex_clear=1. Redirect overrides load-use stall.
- Default (neither condition): pc_en=1, if_id_en=1, both clears 0.

## Timing
- All forwarding and hazard outputs are purely combinational from the current inputs, with zero latency.
- CSR outputs reflect new values one clk edge after csr_we.
- rst asserted at any time immediately forces all CSRs and douts to 0, including mid-write. It is released synchronously by clk, with the first write possible on the first edge after deassertion.
- Combinational outputs are unaffected by rst.

## Test plan
- rst pulse, then csr_we=1 with mepc_din=0x1234 and mipd_din=1, one edge → mepc_dout=0x1234, mipd_dout=1. Then csr_debug_addr=0x341 → 0x1234; 0x7FF → 0.
- mem_is=add x5,x1,x2 and ex_is=add x6,x5,x5 → sr1=sr2=1. With wb_is also writing x5, the selects stay 1 (MEM priority).
- ex_is=lw x7,0(x1) and id_is=add x8,x7,x0 → pc_en=0, if_id_en=0, id_ex_clear=1. Adding npc_mux_sel=1 → pc_en=1, if_id_clear=1, id_ex_clear=1.
- wb_is=lw x9 and ex_is=beq x9,x0 → b_sr1=2, b_sr2=0, sr2=0.
- ex_is=sw x3,0(x4) with mem_is writing x3 → dm_sr2=1, sr2=0. mem_is writing x0 → all selects 0.
- csr_we=1 held while rst asserts → all douts 0 immediately and remain 0 until after rst deasserts.
